id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID→EX pipeline register for the 16-bit five-stage core.
- Captures the decoded instruction, operands, immediate and control bits from decode, and presents them to execute.
- Its registered instr/regdst/regWriteEn outputs are the EX-side inputs of the forwarding/hazard unit. That unit's load-use stall request comes back into this block.
- Owns bubble insertion, flush and halt sequencing, with a small FSM that guarantees exactly one bubble per load-use hazard.

Parameters:
- DATA_W, 16, width of instruction, PC, operand and immediate fields
- NOP_INSTR, 16'h0800, bubble encoding (opcode 5'b00001, NOP)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- instr_dec  in  DATA_W  instruction in decode
- pc_dec  in  DATA_W  PC+2 of the decode instruction
- rs_data_dec  in  DATA_W  register file read port 1
- rt_data_dec  in  DATA_W  register file read port 2
- imm_dec  in  DATA_W  sign/zero-extended immediate
- regdst_dec  in  2  destination select (00 [4:2], 01 [7:5], 10 [10:8], 11 R7)
- regWriteEn_dec  in  1  writeback enable
- muxselB_dec  in  1  ALU B-operand select
- memRead_dec  in  1  load
- memWrite_dec  in  1  store
- ldStall  in  1  load-use stall request from the hazard unit
- flush  in  1  branch/jump redirect resolved in EX
- instr_ex  out  DATA_W  registered instruction
- pc_ex, rs_data_ex, rt_data_ex, imm_ex  out  DATA_W  registered data fields
- regdst_ex  out  2  registered control field
- regWriteEn_ex, muxselB_ex, memRead_ex, memWrite_ex  out  1  registered control fields
- valid_ex  out  1  EX holds a real instruction, not a bubble
- stall_id  out  1  freeze PC and IF/ID this cycle (combinational)
- halted  out  1  HALT has entered EX; pipeline front is frozen

Behaviour:
- Reset (rst==0 at an edge):
  - instr_ex=NOP_INSTR; all data outputs 0; all control outputs 0; regdst_ex=2'b00.
  - valid_ex=0; halted=0; FSM→RUN.
- FSM states: RUN, BUBBLE, HALT. Each edge is evaluated in priority order below.
- flush=1 (any state except HALT):
  - Load bubble: instr_ex=NOP_INSTR, all write/mem enables 0, valid_ex=0.
  - Next state RUN. ldStall is ignored that cycle.
- RUN, ldStall=1:
  - Load bubble; stall_id=1 the same cycle; next state BUBBLE.
- RUN, otherwise:
  - Capture all *_dec fields; valid_ex=1.
  - If instr_dec[15:11]==5'b00000 (HALT), next state HALT; otherwise stay in RUN.
- BUBBLE:
  - Capture the decode fields unconditionally; valid_ex=1.
  - ldStall is ignored, so a second bubble cannot be inserted for the same load.
  - Next state RUN, or HALT if the captured instruction is HALT.
- HALT:
  - halted=1 and stall_id=1 continuously.
  - Load a bubble every cycle; only reset exits.
- stall_id = (state==RUN & ldStall & ~flush) | (state==HALT). It is combinational, so it takes effect in the cycle the hazard is detected.
- Latency: one cycle from decode to EX outputs.
- A bubble always forces regWriteEn_ex=0 and memWrite_ex=0 regardless of the decode values.
- Reset asserted mid-stall or in HALT takes priority over everything and returns the block to RUN with bubble outputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds output stall_cnt[15:0] and output bubble_cnt[15:0]:
  - stall_cnt increments on each RUN→BUBBLE transition.
  - bubble_cnt increments on every bubble load (stall, flush or halt).
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode constants: OP_HALT=5'b00000, OP_NOP=5'b00001, OP_LD=5'b10001, OP_ST=5'b10000.
  - NOP_INSTR.
  - state encoding typedef idex_state_t {RUN, BUBBLE, HALT}.
- One natural sub-module: idex_ctrl_fsm. It holds the state register, stall_id/halted logic and the bubble select. The parent keeps only the field registers and the bubble mux.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 with instr_dec=16'h4123 → next edge instr_ex=16'h4123, valid_ex=1, all outputs 0/NOP before that edge.
- ldStall=1 held high for 3 cycles with instr_dec=16'hD8A0 → cycle 0: stall_id=1 and EX gets NOP; cycle 1: stall_id=0, EX=16'hD8A0, no second bubble.
- flush=1 and ldStall=1 in the same cycle → EX=NOP, valid_ex=0, stall_id=0, state RUN.
- RUN with regWriteEn_dec=1, memWrite_dec=1 and ldStall=1 → regWriteEn_ex=0, memWrite_ex=0.
- instr_dec=16'h0000 (HALT) → next edge instr_ex=16'h0000, halted=1, stall_id=1 every cycle after; EX=NOP thereafter until rst=0.
- With ID_EX_PERF_CNT_EN: 3 separated load-use stalls plus 1 flush → stall_cnt=3, bubble_cnt=4.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared opcode constants, bubble encoding and FSM state type for the ID/EX stage register.
package id_ex_stage_reg_pkg;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [4:0]  OP_LD     = 5'b10001;
    localparam logic [4:0]  OP_ST     = 5'b10000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } idex_state_t;

endpackage

// File: rtl/id_ex_stage_reg_ctrl_fsm.sv
// Control FSM for ID/EX: tracks RUN/BUBBLE/HALT, decides when EX receives a bubble
// and when the front of the pipe must freeze.
module idex_ctrl_fsm
    import id_ex_stage_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ldStall,
    input  logic       flush,
    input  logic [4:0] op_dec,
    output logic       load_bubble,
    output logic       stall_evt,
    output logic       stall_id,
    output logic       halted
);

    idex_state_t state_q, state_d;

    always_comb begin
        state_d     = state_q;
        load_bubble = 1'b0;
        stall_evt   = 1'b0;
        if (state_q == HALT) begin
            load_bubble = 1'b1;
        end else if (flush) begin
            load_bubble = 1'b1;
            state_d     = RUN;
        end else if (state_q == RUN && ldStall) begin
            load_bubble = 1'b1;
            stall_evt   = 1'b1;
            state_d     = BUBBLE;
        end else begin
            // BUBBLE ignores ldStall so one load never gets two bubbles
            state_d = (op_dec == OP_HALT) ? HALT : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    assign stall_id = (state_q == RUN && ldStall && !flush) || (state_q == HALT);
    assign halted   = (state_q == HALT);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with bubble/flush/halt sequencing.
// Optional ID_EX_PERF_CNT_EN adds saturating stall and bubble counters.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = id_ex_stage_reg_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_dec,
    input  logic [DATA_W-1:0] pc_dec,
    input  logic [DATA_W-1:0] rs_data_dec,
    input  logic [DATA_W-1:0] rt_data_dec,
    input  logic [DATA_W-1:0] imm_dec,
    input  logic [1:0]        regdst_dec,
    input  logic              regWriteEn_dec,
    input  logic              muxselB_dec,
    input  logic              memRead_dec,
    input  logic              memWrite_dec,
    input  logic              ldStall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_ex,
    output logic [DATA_W-1:0] pc_ex,
    output logic [DATA_W-1:0] rs_data_ex,
    output logic [DATA_W-1:0] rt_data_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [1:0]        regdst_ex,
    output logic              regWriteEn_ex,
    output logic              muxselB_ex,
    output logic              memRead_ex,
    output logic              memWrite_ex,
    output logic              valid_ex,
    output logic              stall_id,
    output logic              halted
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    logic load_bubble, stall_evt;

    idex_ctrl_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .ldStall    (ldStall),
        .flush      (flush),
        .op_dec     (instr_dec[DATA_W-1 -: 5]),
        .load_bubble(load_bubble),
        .stall_evt  (stall_evt),
        .stall_id   (stall_id),
        .halted     (halted)
    );

    logic [DATA_W-1:0] instr_q, instr_d, pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
    logic [1:0]        regdst_q, regdst_d;
    logic              wen_q, wen_d, selb_q, selb_d, mrd_q, mrd_d, mwr_q, mwr_d, valid_q, valid_d;

    // A bubble is the reset image: NOP with every enable and field cleared
    always_comb begin
        instr_d  = NOP_INSTR;
        pc_d     = '0;
        rs_d     = '0;
        rt_d     = '0;
        imm_d    = '0;
        regdst_d = 2'b00;
        wen_d    = 1'b0;
        selb_d   = 1'b0;
        mrd_d    = 1'b0;
        mwr_d    = 1'b0;
        valid_d  = 1'b0;
        if (!load_bubble) begin
            instr_d  = instr_dec;
            pc_d     = pc_dec;
            rs_d     = rs_data_dec;
            rt_d     = rt_data_dec;
            imm_d    = imm_dec;
            regdst_d = regdst_dec;
            wen_d    = regWriteEn_dec;
            selb_d   = muxselB_dec;
            mrd_d    = memRead_dec;
            mwr_d    = memWrite_dec;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q  <= NOP_INSTR;
            pc_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            regdst_q <= 2'b00;
            wen_q    <= 1'b0;
            selb_q   <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            regdst_q <= regdst_d;
            wen_q    <= wen_d;
            selb_q   <= selb_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_ex      = instr_q;
    assign pc_ex         = pc_q;
    assign rs_data_ex    = rs_q;
    assign rt_data_ex    = rt_q;
    assign imm_ex        = imm_q;
    assign regdst_ex     = regdst_q;
    assign regWriteEn_ex = wen_q;
    assign muxselB_ex    = selb_q;
    assign memRead_ex    = mrd_q;
    assign memWrite_ex   = mwr_q;
    assign valid_ex      = valid_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_evt && stall_cnt_q != 16'hFFFF)    stall_cnt_d  = stall_cnt_q + 16'd1;
        if (load_bubble && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= 16'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_stall_evt;
    assign unused_stall_evt = stall_evt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, capture, load-use bubble, flush, halt.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_dec, pc_dec, rs_data_dec, rt_data_dec, imm_dec;
    logic [1:0]  regdst_dec;
    logic        regWriteEn_dec, muxselB_dec, memRead_dec, memWrite_dec, ldStall, flush;
    logic [15:0] instr_ex, pc_ex, rs_data_ex, rt_data_ex, imm_ex;
    logic [1:0]  regdst_ex;
    logic        regWriteEn_ex, muxselB_ex, memRead_ex, memWrite_ex, valid_ex, stall_id, halted;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .instr_dec(instr_dec), .pc_dec(pc_dec), .rs_data_dec(rs_data_dec),
        .rt_data_dec(rt_data_dec), .imm_dec(imm_dec), .regdst_dec(regdst_dec),
        .regWriteEn_dec(regWriteEn_dec), .muxselB_dec(muxselB_dec),
        .memRead_dec(memRead_dec), .memWrite_dec(memWrite_dec),
        .ldStall(ldStall), .flush(flush),
        .instr_ex(instr_ex), .pc_ex(pc_ex), .rs_data_ex(rs_data_ex),
        .rt_data_ex(rt_data_ex), .imm_ex(imm_ex), .regdst_ex(regdst_ex),
        .regWriteEn_ex(regWriteEn_ex), .muxselB_ex(muxselB_ex),
        .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
        .valid_ex(valid_ex), .stall_id(stall_id), .halted(halted)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ldStall = 1'b0;
        instr_dec = 16'h4123; pc_dec = 16'h0102; rs_data_dec = 16'h1111;
        rt_data_dec = 16'h2222; imm_dec = 16'h0033; regdst_dec = 2'b01;
        regWriteEn_dec = 1'b1; muxselB_dec = 1'b1; memRead_dec = 1'b0; memWrite_dec = 1'b0;
        tick(); tick();
        chk("rst_instr",  instr_ex, 16'h0800);
        chk("rst_valid",  valid_ex, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall",  stall_id, 0);
        chk("rst_pc",     pc_ex, 0);
        chk("rst_wen",    regWriteEn_ex, 0);
        chk("rst_regdst", regdst_ex, 0);

        rst = 1'b1;
        tick();
        chk("cap_instr",  instr_ex, 16'h4123);
        chk("cap_valid",  valid_ex, 1);
        chk("cap_pc",     pc_ex, 16'h0102);
        chk("cap_rs",     rs_data_ex, 16'h1111);
        chk("cap_rt",     rt_data_ex, 16'h2222);
        chk("cap_imm",    imm_ex, 16'h0033);
        chk("cap_regdst", regdst_ex, 2'b01);
        chk("cap_wen",    regWriteEn_ex, 1);
        chk("cap_selb",   muxselB_ex, 1);

        // load-use hazard held 3 cycles
        instr_dec = 16'hD8A0; regWriteEn_dec = 1'b1; memWrite_dec = 1'b1; memRead_dec = 1'b1;
        ldStall = 1'b1;
        #1;
        chk("ld0_stall", stall_id, 1);
        tick();
        chk("ld0_instr", instr_ex, 16'h0800);
        chk("ld0_valid", valid_ex, 0);
        chk("ld0_wen",   regWriteEn_ex, 0);
        chk("ld0_mwr",   memWrite_ex, 0);
        chk("ld0_mrd",   memRead_ex, 0);
        chk("ld1_stall", stall_id, 0);
        tick();
        chk("ld1_instr", instr_ex, 16'hD8A0);
        chk("ld1_valid", valid_ex, 1);
        chk("ld1_mwr",   memWrite_ex, 1);
        chk("ld1_wen",   regWriteEn_ex, 1);
        chk("ld2_stall", stall_id, 1);
        tick();
        chk("ld2_instr", instr_ex, 16'h0800);
        ldStall = 1'b0; instr_dec = 16'h1234; memWrite_dec = 1'b0; memRead_dec = 1'b0;
        tick();
        chk("ld3_instr", instr_ex, 16'h1234);
        chk("ld3_valid", valid_ex, 1);

        // flush wins over ldStall, FSM stays in RUN
        flush = 1'b1; ldStall = 1'b1; instr_dec = 16'h5555;
        #1;
        chk("fl_stall", stall_id, 0);
        tick();
        chk("fl_instr", instr_ex, 16'h0800);
        chk("fl_valid", valid_ex, 0);
        chk("fl_wen",   regWriteEn_ex, 0);
        flush = 1'b0;
        #1;
        chk("fl_run_stall", stall_id, 1);
        tick();
        chk("fl_bub_instr", instr_ex, 16'h0800);
        ldStall = 1'b0;
        tick();
        chk("fl_cap_instr", instr_ex, 16'h5555);

        // HALT enters EX, then the block bubbles until reset
        instr_dec = 16'h0000; regWriteEn_dec = 1'b1; memWrite_dec = 1'b1;
        tick();
        chk("h0_instr",  instr_ex, 16'h0000);
        chk("h0_valid",  valid_ex, 1);
        chk("h0_halted", halted, 1);
        chk("h0_stall",  stall_id, 1);
        instr_dec = 16'h4123; flush = 1'b1;
        tick();
        chk("h1_instr",  instr_ex, 16'h0800);
        chk("h1_valid",  valid_ex, 0);
        chk("h1_halted", halted, 1);
        chk("h1_stall",  stall_id, 1);
        chk("h1_mwr",    memWrite_ex, 0);
        flush = 1'b0;
        tick();
        chk("h2_instr",  instr_ex, 16'h0800);
        chk("h2_halted", halted, 1);
        rst = 1'b0;
        tick();
        chk("hr_halted", halted, 0);
        chk("hr_stall",  stall_id, 0);
        chk("hr_instr",  instr_ex, 16'h0800);
        chk("hr_valid",  valid_ex, 0);
        rst = 1'b1; memWrite_dec = 1'b0;
        tick();
        chk("hr_cap", instr_ex, 16'h4123);

`ifdef ID_EX_PERF_CNT_EN
        rst = 1'b0;
        tick();
        chk("pc_rst_s", stall_cnt, 0);
        chk("pc_rst_b", bubble_cnt, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ldStall = 1'b1; tick();
            ldStall = 1'b0; tick();
            tick();
        end
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        chk("pc_stall",  stall_cnt, 3);
        chk("pc_bubble", bubble_cnt, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
